// File: rtl/user_bank_pkg.sv
// Shared types and constants for the user data bank: FSM states, host address map,
// STATUS bit positions and a saturating counter helper.
package user_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StDone
  } state_t;

  // Host word-address map
  localparam logic [7:0] InBase     = 8'h00;
  localparam logic [7:0] OutBase    = 8'h40;
  localparam logic [7:0] CtrlAddr   = 8'h80;
  localparam logic [7:0] StatusAddr = 8'h81;
  localparam logic [7:0] CyclesAddr = 8'h82;

  // STATUS bit positions
  localparam int unsigned StatBusy     = 0;
  localparam int unsigned StatDone     = 1;
  localparam int unsigned StatTimeout  = 2;
  localparam int unsigned StatStartRej = 3;
  localparam int unsigned StatWrBusy   = 4;

  // data_out_addr value the functional module uses to signal completion
  localparam logic [7:0] DoneMarkerDefault = 8'h89;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/user_bank_ram.sv
// Word bank: one synchronous write port, NumRd combinational read ports, whole array
// cleared by the asynchronous reset.
module user_bank_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned NumRd = 1,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [Aw-1:0]              waddr,
  input  logic [31:0]                wdata,
  input  logic [NumRd-1:0][Aw-1:0]   raddr,
  output logic [NumRd-1:0][31:0]     rdata
);

  logic [31:0] mem_q [Depth];

  // Storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read ports
  always_comb begin
    for (int p = 0; p < int'(NumRd); p++) begin
      rdata[p] = mem_q[raddr[p]];
    end
  end

endmodule

// File: rtl/user_data_bank.sv
// Host-side companion of the user functional module: owns the input bank the module reads,
// captures its result sweep into the output bank, runs the start/run/done handshake with a
// cycle limit, and exposes CTRL/STATUS/CYCLES to the register slave.
module user_data_bank
  import user_bank_pkg::*;
#(
  parameter int unsigned DEPTH          = 64,
  parameter logic [7:0]  DONE_MARKER    = DoneMarkerDefault,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_wr_en,
  input  logic [7:0]  host_wr_addr,
  input  logic [31:0] host_wr_data,
  input  logic        host_rd_en,
  input  logic [7:0]  host_rd_addr,
  output logic [31:0] host_rd_data,
  output logic        host_rd_valid,
  output logic        user_start,
  input  logic [7:0]  data_in_addr,
  output logic [31:0] data_in,
  input  logic [7:0]  data_out_addr,
  input  logic [31:0] data_out,
  output logic        irq_done
);

  localparam int unsigned Aw     = $clog2(DEPTH);
  localparam logic [8:0]  DepthW = 9'(DEPTH);

  state_t state_q, state_d;

  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        start_rej_q, start_rej_d;
  logic        wr_busy_q, wr_busy_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q;

  logic        idle;
  logic        in_wr_hit, in_we;
  logic        ctrl_start, start_acc, start_rej_ev;
  logic        status_wr;
  logic        marker_hit, timeout_hit;
  logic        capture, set_done, set_timeout;
  logic        in_rd_hit, out_rd_hit, mod_rd_hit;
  logic [7:0]  in_wr_off, in_rd_off, out_rd_off;
  logic [31:0] status_word;

  logic [1:0][Aw-1:0] in_raddr;
  logic [1:0][31:0]   in_rdata;
  logic [0:0][Aw-1:0] out_raddr;
  logic [0:0][31:0]   out_rdata;

  // Address decode and host event qualification
  always_comb begin
    idle         = (state_q == StIdle);
    in_wr_off    = host_wr_addr - InBase;
    in_rd_off    = host_rd_addr - InBase;
    out_rd_off   = host_rd_addr - OutBase;
    in_wr_hit    = host_wr_en && (host_wr_addr >= InBase) &&
                   ({1'b0, host_wr_addr} < ({1'b0, InBase} + DepthW));
    in_we        = in_wr_hit && idle;
    ctrl_start   = host_wr_en && (host_wr_addr == CtrlAddr) && host_wr_data[0];
    start_acc    = ctrl_start && idle;
    start_rej_ev = ctrl_start && !idle;
    status_wr    = host_wr_en && (host_wr_addr == StatusAddr);
    in_rd_hit    = (host_rd_addr >= InBase) &&
                   ({1'b0, host_rd_addr} < ({1'b0, InBase} + DepthW));
    out_rd_hit   = (host_rd_addr >= OutBase) &&
                   ({1'b0, host_rd_addr} < ({1'b0, OutBase} + DepthW));
    mod_rd_hit   = ({1'b0, data_in_addr} < DepthW);
    marker_hit   = (data_out_addr == DONE_MARKER);
    // Counter value after this RUN cycle reaching the limit ends the run
    timeout_hit  = (TIMEOUT_CYCLES != 0) &&
                   (({1'b0, cycles_q} + 33'd1) >= 33'(TIMEOUT_CYCLES));
  end

  // Offsets are only meaningful in their low Aw bits once the range check passed
  logic unused_off;
  assign unused_off = ^{in_wr_off[7:Aw], in_rd_off[7:Aw], out_rd_off[7:Aw]};

  // Next-state, handshake outputs and run-cycle counter
  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    user_start  = 1'b0;
    irq_done    = 1'b0;
    capture     = 1'b0;
    set_done    = 1'b0;
    set_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          state_d  = StStart;
          cycles_d = '0;
        end
      end
      StStart: begin
        user_start = 1'b1;
        state_d    = StRun;
      end
      StRun: begin
        cycles_d = sat_inc(cycles_q);
        capture  = ({1'b0, data_out_addr} < DepthW);
        // Marker takes priority over an expiring timeout in the same cycle
        if (marker_hit) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d     = StIdle;
          set_timeout = 1'b1;
        end
      end
      StDone: begin
        irq_done = 1'b1;
        set_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky STATUS bits: W1C, a same-cycle set event wins over the clear
  always_comb begin
    done_d      = start_acc ? 1'b0 :
                  ((done_q && !(status_wr && host_wr_data[StatDone])) || set_done);
    timeout_d   = (timeout_q && !(status_wr && host_wr_data[StatTimeout])) || set_timeout;
    start_rej_d = (start_rej_q && !(status_wr && host_wr_data[StatStartRej])) || start_rej_ev;
    wr_busy_d   = (wr_busy_q && !(status_wr && host_wr_data[StatWrBusy])) ||
                  (in_wr_hit && !idle);
  end

  // STATUS word assembly
  always_comb begin
    status_word               = '0;
    status_word[StatBusy]     = !idle;
    status_word[StatDone]     = done_q;
    status_word[StatTimeout]  = timeout_q;
    status_word[StatStartRej] = start_rej_q;
    status_word[StatWrBusy]   = wr_busy_q;
  end

  // Host read mux; sampled before this cycle's write lands, so reads see old data
  always_comb begin
    rd_data_d = '0;
    if (in_rd_hit) begin
      rd_data_d = in_rdata[1];
    end else if (out_rd_hit) begin
      rd_data_d = out_rdata[0];
    end else if (host_rd_addr == StatusAddr) begin
      rd_data_d = status_word;
    end else if (host_rd_addr == CyclesAddr) begin
      rd_data_d = cycles_q;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      start_rej_q <= 1'b0;
      wr_busy_q   <= 1'b0;
      cycles_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      start_rej_q <= start_rej_d;
      wr_busy_q   <= wr_busy_d;
      cycles_q    <= cycles_d;
      rd_data_q   <= host_rd_en ? rd_data_d : '0;
      rd_valid_q  <= host_rd_en;
    end
  end

  assign host_rd_data  = rd_data_q;
  assign host_rd_valid = rd_valid_q;

  // Port 0 feeds the functional module, port 1 the host
  assign in_raddr[0] = data_in_addr[Aw-1:0];
  assign in_raddr[1] = in_rd_off[Aw-1:0];
  assign out_raddr[0] = out_rd_off[Aw-1:0];

  assign data_in = mod_rd_hit ? in_rdata[0] : '0;

  user_bank_ram #(
    .Depth (DEPTH),
    .NumRd (2),
    .Aw    (Aw)
  ) u_in_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (in_we),
    .waddr (in_wr_off[Aw-1:0]),
    .wdata (host_wr_data),
    .raddr (in_raddr),
    .rdata (in_rdata)
  );

  user_bank_ram #(
    .Depth (DEPTH),
    .NumRd (1),
    .Aw    (Aw)
  ) u_out_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (capture),
    .waddr (data_out_addr[Aw-1:0]),
    .wdata (data_out),
    .raddr (out_raddr),
    .rdata (out_rdata)
  );

endmodule

// File: tb/tb_user_data_bank.sv
// Self-checking bench for user_data_bank: the bench plays both the host and the functional
// module, and keeps its own image of both banks and of STATUS/CYCLES.
module tb_user_data_bank;

  localparam int unsigned ToCycles = 80;
  localparam logic [7:0]  CtrlA    = 8'h80;
  localparam logic [7:0]  StatusA  = 8'h81;
  localparam logic [7:0]  CyclesA  = 8'h82;
  localparam logic [7:0]  Marker   = 8'h89;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_wr_en;
  logic [7:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic        host_rd_en;
  logic [7:0]  host_rd_addr;
  logic [31:0] host_rd_data;
  logic        host_rd_valid;
  logic        user_start;
  logic [7:0]  data_in_addr;
  logic [31:0] data_in;
  logic [7:0]  data_out_addr;
  logic [31:0] data_out;
  logic        irq_done;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int irq_cnt   = 0;

  logic [31:0] in_ref  [64];
  logic [31:0] out_ref [64];

  always #5 clk = ~clk;

  user_data_bank #(
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_wr_en    (host_wr_en),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_rd_en    (host_rd_en),
    .host_rd_addr  (host_rd_addr),
    .host_rd_data  (host_rd_data),
    .host_rd_valid (host_rd_valid),
    .user_start    (user_start),
    .data_in_addr  (data_in_addr),
    .data_in       (data_in),
    .data_out_addr (data_out_addr),
    .data_out      (data_out),
    .irq_done      (irq_done)
  );

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (user_start) start_cnt++;
    if (irq_done) irq_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    host_wr_en = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d);
    host_rd_en = 1'b1;
    host_rd_addr = a;
    tick();
    host_rd_en = 1'b0;
    check("rd_valid", {31'd0, host_rd_valid}, 32'd1);
    d = host_rd_data;
  endtask

  task automatic drive(input logic [7:0] a, input logic [31:0] d);
    data_out_addr = a;
    data_out = d;
    tick();
  endtask

  // Wait (bounded) for the start pulse, then step into the first RUN cycle
  task automatic enter_run();
    for (int k = 0; k < 8 && !user_start; k++) tick();
    check("start_seen", {31'd0, user_start}, 32'd1);
    tick();
  endtask

  function automatic logic [7:0] rand_addr_no_marker();
    logic [7:0] a;
    a = 8'($urandom);
    if (a == Marker) a = 8'h8A;
    return a;
  endfunction

  task automatic check_out_bank(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      host_read(8'(8'h40 + i), v);
      check(tag, v, out_ref[i]);
    end
  endtask

  initial begin
    logic [31:0] rd, rd2, d, x;
    logic [7:0]  a;
    int          g;

    host_wr_en = 0; host_wr_addr = 0; host_wr_data = 0;
    host_rd_en = 0; host_rd_addr = 0;
    data_in_addr = 0; data_out_addr = 0; data_out = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_user_start", {31'd0, user_start}, 32'd0);
    check("rst_irq", {31'd0, irq_done}, 32'd0);
    check("rst_rd_valid", {31'd0, host_rd_valid}, 32'd0);
    check("rst_rd_data", host_rd_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    host_read(StatusA, rd); check("rst_status", rd, 32'd0);
    host_read(CyclesA, rd); check("rst_cycles", rd, 32'd0);

    // Load the input bank
    for (int i = 0; i < 64; i++) begin
      in_ref[i] = $urandom;
      out_ref[i] = 32'd0;
      host_write(8'(i), in_ref[i]);
    end
    for (int k = 0; k < 12; k++) begin
      a = (k < 6) ? 8'($urandom_range(0, 63)) : 8'($urandom);
      data_in_addr = a;
      tick();
      check("data_in", data_in, (a < 8'd64) ? in_ref[a[5:0]] : 32'd0);
    end
    host_read(8'd9, rd); check("in_bank_rd", rd, in_ref[9]);

    // Same-cycle read and write: read returns the old word
    x = $urandom;
    host_wr_en = 1'b1; host_wr_addr = 8'd7; host_wr_data = x;
    host_rd_en = 1'b1; host_rd_addr = 8'd7;
    tick();
    host_wr_en = 1'b0; host_rd_en = 1'b0;
    check("rw_same_old", host_rd_data, in_ref[7]);
    in_ref[7] = x;
    host_read(8'd7, rd); check("rw_same_new", rd, x);

    // Result traffic while idle must not be captured
    drive(8'd3, $urandom);
    drive(8'd0, 32'd0);

    // Normal run: garbage traffic, full inverted sweep, marker
    host_write(CtrlA, 32'd1);
    enter_run();
    g = $urandom_range(0, 10);
    fork
      begin
        for (int k = 0; k < g; k++) begin
          a = rand_addr_no_marker();
          d = $urandom;
          if (a < 8'd64) out_ref[a[5:0]] = d;
          drive(a, d);
        end
        for (int i = 0; i < 64; i++) begin
          data_in_addr = 8'(i);
          #1;
          data_out_addr = 8'(i);
          data_out = ~data_in;
          out_ref[i] = ~in_ref[i];
          tick();
        end
        drive(Marker, $urandom);
        data_out_addr = 8'd0;
        tick();
      end
      begin
        repeat (3) tick();
        host_write(CtrlA, 32'd1);
        host_write(8'd5, 32'hDEAD);
        host_read(StatusA, rd2);
        check("status_in_run", rd2, 32'h19);
      end
    join
    check("start_pulses", start_cnt, 1);
    check("irq_pulses", irq_cnt, 1);
    host_read(StatusA, rd); check("status_after_run", rd, 32'h1A);
    host_read(CyclesA, rd); check("cycles_run", rd, 32'(g + 65));
    host_read(8'd5, rd); check("in5_kept", rd, in_ref[5]);
    check_out_bank("out_bank_run");
    host_write(StatusA, 32'h8);
    host_read(StatusA, rd); check("w1c_start_rej", rd, 32'h12);
    host_write(StatusA, 32'h10);
    host_read(StatusA, rd); check("w1c_wr_busy", rd, 32'h02);

    // Timeout: no marker ever arrives
    host_write(CtrlA, 32'd1);
    enter_run();
    for (int k = 0; k < int'(ToCycles) + 5; k++) begin
      a = rand_addr_no_marker();
      d = $urandom;
      if (k < int'(ToCycles) && a < 8'd64) out_ref[a[5:0]] = d;
      drive(a, d);
    end
    data_out_addr = 8'd0;
    host_read(StatusA, rd); check("status_timeout", rd, 32'h4);
    host_read(CyclesA, rd); check("cycles_timeout", rd, ToCycles);
    check("irq_timeout", irq_cnt, 1);
    check_out_bank("out_bank_to");

    // Marker in the very cycle the limit expires
    host_write(StatusA, 32'h4);
    host_read(StatusA, rd); check("w1c_timeout", rd, 32'h0);
    host_write(CtrlA, 32'd1);
    enter_run();
    for (int k = 0; k < int'(ToCycles) - 1; k++) begin
      a = 8'($urandom_range(0, 63));
      d = $urandom;
      out_ref[a[5:0]] = d;
      drive(a, d);
    end
    drive(Marker, 32'd0);
    data_out_addr = 8'd0;
    tick();
    check("irq_marker_wins", irq_cnt, 2);
    host_read(StatusA, rd); check("status_marker_wins", rd, 32'h2);
    host_read(CyclesA, rd); check("cycles_marker_wins", rd, ToCycles);
    host_read(8'h40 + 8'd17, rd); check("out17_marker_wins", rd, out_ref[17]);

    // Reset in the middle of a run
    host_write(CtrlA, 32'd1);
    enter_run();
    drive(8'd0, 32'h1234_5678);
    host_rd_en = 1'b1; host_rd_addr = 8'd1;
    data_in_addr = 8'd1;
    #2 rst_n = 1'b0;
    #1;
    host_rd_en = 1'b0;
    check("rst_mid_user_start", {31'd0, user_start}, 32'd0);
    check("rst_mid_irq", {31'd0, irq_done}, 32'd0);
    check("rst_mid_rd_valid", {31'd0, host_rd_valid}, 32'd0);
    check("rst_mid_rd_data", host_rd_data, 32'd0);
    check("rst_mid_data_in", data_in, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    host_read(StatusA, rd); check("rst_mid_status", rd, 32'd0);
    host_read(CyclesA, rd); check("rst_mid_cycles", rd, 32'd0);
    host_read(8'h00, rd); check("rst_mid_in0", rd, 32'd0);
    host_read(8'h40, rd); check("rst_mid_out0", rd, 32'd0);
    check("start_total", start_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
